booth_r4_seq_mult: RTL

Parametrised, sequential radix-4 Booth multiplier with valid/ready handshakes on both sides and run-time signed/unsigned mode. It retires one Booth digit per clock into a shifting accumulator and skips the accumulator update on zero digits to save switching power. A per-operation zero-digit count is exported for power profiling. It is the iterative multiplier core for the power-efficient Booth datapath and feeds the downstream accumulate/writeback stage.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_r4_ppgen.sv | 25 ++
 rtl/booth_r4_seq_mult.sv | 94 +++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and the radix-4 Booth window encoder
package booth_pkg;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    // {m[2],m[1],m[0]} -> digit in {0,+1,+2,-1,-2}
    function automatic booth_digit_e booth_encode(input logic [2:0] w);
        return (w == 3'b000 || w == 3'b111) ? ZERO :
               (w == 3'b011) ? POS2 :
               (w == 3'b100) ? NEG2 :
               w[2] ? NEG1 : POS1;
    endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// booth_r4_ppgen: combinational radix-4 Booth partial-product generator
// Ports: window (3-bit multiplier window), md (N+2-bit extended multiplicand),
//        pp (digit x md, N+2 bits), is_zero (digit is 0)
module booth_r4_ppgen
    import booth_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   window,
    input  logic [N+1:0] md,
    output logic [N+1:0] pp,
    output logic         is_zero
);

    booth_digit_e digit;
    logic [N+1:0] mag;

    always_comb begin
        digit   = booth_encode(window);
        mag     = (digit == POS2 || digit == NEG2) ? md << 1 : md;
        pp      = (digit == ZERO) ? '0 : (digit == NEG1 || digit == NEG2) ? -mag : mag;
        is_zero = digit == ZERO;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, one digit per clock
// Ports: clk, reset (async, active-high); in_valid/in_ready/signed_mode/md/mr
//        operand handshake; out_valid/out_ready/product/zero_digits result
//        handshake (product = md*mr, zero_digits = count of zero Booth digits)
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N/2+2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [N-1:0]     md,
    input  logic [N-1:0]     mr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic [CNT_W-1:0] zero_digits
);

    localparam int W = N + 3;

    state_e           state;
    logic [N+1:0]     md_q;
    logic [W-1:0]     acc;
    logic [W-1:0]     mreg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] zcnt;
    logic             sgn;
    logic [N+1:0]     pp;
    logic             is_zero;
    logic [W-1:0]     acc_sum;
    logic [2*W-1:0]   shifted;
    logic             accept;
    logic             ext_md;
    logic             ext_mr;

    booth_r4_ppgen #(.N(N)) u_ppgen (
        .window  (mreg[2:0]),
        .md      (md_q),
        .pp      (pp),
        .is_zero (is_zero)
    );

    assign in_ready = state == IDLE || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign ext_md   = signed_mode & md[N-1];
    assign ext_mr   = signed_mode & mr[N-1];
    // zero digits leave acc untouched so its adder inputs do not toggle
    assign acc_sum  = is_zero ? acc : acc + {pp[N+1], pp};
    assign shifted  = $signed({acc_sum, mreg}) >>> 2;

    // after D shifts the weight-1 bit sits at index N+3-2D: 3 signed, 1 unsigned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            product     <= '0;
            zero_digits <= '0;
            md_q        <= '0;
            acc         <= '0;
            mreg        <= '0;
            cnt         <= '0;
            zcnt        <= '0;
            sgn         <= 1'b0;
        end else if (accept) begin
            state     <= CALC;
            out_valid <= 1'b0;
            md_q      <= {{2{ext_md}}, md};
            mreg      <= {{2{ext_mr}}, mr, 1'b0};
            acc       <= '0;
            cnt       <= signed_mode ? CNT_W'(N/2) : CNT_W'(N/2 + 1);
            zcnt      <= '0;
            sgn       <= signed_mode;
        end else if (state == CALC) begin
            {acc, mreg} <= shifted;
            cnt         <= cnt - 1'b1;
            zcnt        <= zcnt + CNT_W'(is_zero);
            if (cnt == CNT_W'(1)) begin
                state       <= DONE;
                out_valid   <= 1'b1;
                product     <= sgn ? shifted[3 +: 2*N] : shifted[1 +: 2*N];
                zero_digits <= zcnt + CNT_W'(is_zero);
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule
